// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: one inverse round per clock on an external datapath.
// Byte i of every state/key bus sits at bits [8*(4*Nb-1-i) +: 8], so byte 0 is the MSB.
module aes_inv_cipher_ctrl #(
    parameter int unsigned Nb = 4,
    parameter int unsigned Nr = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_ready_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [32*Nb-1:0]  in_data_i,
    output logic [3:0]        rk_idx_o,
    input  logic [32*Nb-1:0]  rk_data_i,
    output logic [32*Nb-1:0]  rnd_state_o,
    output logic              rnd_final_o,
    input  logic [32*Nb-1:0]  rnd_result_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [32*Nb-1:0]  out_data_o,
    output logic              busy_o
);

    localparam int unsigned W         = 32 * Nb;
    localparam logic [3:0]  RK_LAST   = 4'(Nr);
    localparam logic [3:0]  RND_FIRST = 4'(Nr - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [W-1:0]   st_q, st_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        in_ready_o  = 1'b0;
        rk_idx_o    = RK_LAST;
        rnd_final_o = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready_o = key_ready_i;
                // Initial AddRoundKey with key Nr happens on the accepting edge itself.
                if (in_valid_i && key_ready_i) begin
                    st_d    = in_data_i ^ rk_data_i;
                    rnd_d   = RND_FIRST;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                busy_o      = 1'b1;
                rk_idx_o    = rnd_q;
                rnd_final_o = (rnd_q == 4'd0);
                st_d        = rnd_result_i;
                if (rnd_q != 4'd0) begin
                    rnd_d = rnd_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rnd_state_o = st_q;
    assign out_data_o  = st_q;

endmodule
